// File: rtl/signed_diff_accumulator.sv
// signed_diff_accumulator
// Sums N_SAMPLES signed 5-bit differences per frame into a signed ACC_W-bit total.
// A frame begins with a start pulse in IDLE. It then accepts diffs in ACCUM.
// In DONE it presents the sum for one cycle with acc_valid high.
// Optional feature macro: SIGNED_DIFF_ACC_SAT_EN
//   defined   -> each addition saturates and sat_flag is sticky for the frame
//   undefined -> additions wrap modulo 2^ACC_W and sat_flag is tied to 0
//
// Handshake: a diff is consumed on a rising edge only when diff_valid and
// diff_ready are both 1. diff_ready is a pure decode of the state: it is 1
// exactly in ACCUM and never depends on diff_valid. Low diff_valid in ACCUM
// stalls the frame without side effects.
module signed_diff_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [4:0]       diff,
    input  logic                    diff_valid,
    output logic                    diff_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_valid,
    output logic                    sat_flag,
    output logic                    busy,
    output logic [1:0]              fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Counter value that marks the final sample of the frame.
    localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

    logic [1:0]              state;
    logic [7:0]              cnt;
    logic                    accept;
    logic signed [ACC_W-1:0] next_acc;
    logic                    clamp;

    assign accept     = (state == S_ACCUM) && diff_valid;
    assign diff_ready = (state == S_ACCUM);
    assign acc_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign fsm_state  = state;

`ifdef SIGNED_DIFF_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  sat_q;

    // Add with one guard bit. A guard bit that disagrees with the sign bit
    // means overflow, so the result is clamped toward the sign of the true sum.
    always_comb begin
        sum_wide = {acc_out[ACC_W-1], acc_out} + {{(ACC_W-4){diff[4]}}, diff};
        clamp    = 1'b0;
        next_acc = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            clamp    = 1'b1;
            next_acc = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sticky clamp indicator. It clears at frame start and holds with acc_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sat_q <= 1'b0;
        end else if (accept && clamp) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic signed [ACC_W-1:0] diff_ext;

    // Wrap-around addition. Dropping the guard bit gives modulo 2^ACC_W.
    always_comb begin
        diff_ext = {{(ACC_W-5){diff[4]}}, diff};
        next_acc = acc_out + diff_ext;
        clamp    = 1'b0;
    end

    assign sat_flag = clamp;
`endif

    // Frame sequencing: start in IDLE opens a frame, and the last accepted
    // sample closes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_ACCUM;
                S_ACCUM: if (accept && cnt == LAST_IDX) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Accumulator and sample counter. Both clear at frame start and advance
    // only on accepted diffs. acc_out holds its value outside ACCUM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= '0;
            cnt     <= '0;
        end else if (state == S_IDLE && start) begin
            acc_out <= '0;
            cnt     <= '0;
        end else if (accept) begin
            acc_out <= next_acc;
            cnt     <= cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_signed_diff_accumulator.sv
// Bench for signed_diff_accumulator: two instances (ACC_W=8 and ACC_W=6,
// both N_SAMPLES=4) driven in lockstep, checked against an integer model.
module tb_signed_diff_accumulator;

`ifdef SIGNED_DIFF_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [4:0] diff;
    logic       diff_valid;

    logic              ready_a, valid_a, sat_a, busy_a;
    logic signed [7:0] acc_a;
    logic [1:0]        st_a;
    logic              ready_b, valid_b, sat_b, busy_b;
    logic signed [5:0] acc_b;
    logic [1:0]        st_b;

    signed_diff_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(start), .diff(diff),
        .diff_valid(diff_valid), .diff_ready(ready_a), .acc_out(acc_a),
        .acc_valid(valid_a), .sat_flag(sat_a), .busy(busy_a), .fsm_state(st_a)
    );

    signed_diff_accumulator #(.N_SAMPLES(4), .ACC_W(6)) u_dut_w6 (
        .clk(clk), .rst_n(rst_n), .start(start), .diff(diff),
        .diff_valid(diff_valid), .diff_ready(ready_b), .acc_out(acc_b),
        .acc_valid(valid_b), .sat_flag(sat_b), .busy(busy_b), .fsm_state(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: running integer sum, either clamped to the signed range or
    // folded back into it modulo 2^w.
    function automatic void model(input int d[4], input int w,
                                  output int sum, output int sat);
        int lo, hi, m;
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        m   = 1 << w;
        sum = 0;
        sat = 0;
        foreach (d[i]) begin
            sum += d[i];
            if (SAT_EN) begin
                if (sum > hi) begin sum = hi; sat = 1; end
                else if (sum < lo) begin sum = lo; sat = 1; end
            end else begin
                while (sum > hi) sum -= m;
                while (sum < lo) sum += m;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        start = 1'b0; diff_valid = 1'b0; diff = '0;
        rst_n = 1'b0;
        #1;
        check("rst_acc8",   int'(acc_a), 0);
        check("rst_acc6",   int'(acc_b), 0);
        check("rst_valid",  int'(valid_a | valid_b), 0);
        check("rst_busy",   int'(busy_a | busy_b), 0);
        check("rst_ready",  int'(ready_a | ready_b), 0);
        check("rst_sat",    int'(sat_a | sat_b), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one frame starting at a negedge in IDLE. Gap cycles with
    // diff_valid low are inserted before each sample. poke drives start
    // during gaps and in DONE, and diff_valid in DONE.
    task automatic run_frame(input int d[4], input int gmin, input int gmax,
                             input bit poke);
        int e8, s8, e6, s6, g;
        model(d, 8, e8, s8);
        model(d, 6, e6, s6);
        exp_q.push_back(e8);
        check("idle_busy", int'(busy_a), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accum_busy", int'(busy_a & busy_b), 1);
        for (int i = 0; i < 4; i++) begin
            g = int'($urandom_range(gmin, gmax));
            for (int k = 0; k < g; k++) begin
                diff_valid = 1'b0;
                diff = 5'($urandom);
                start = poke;
                @(negedge clk);
                start = 1'b0;
                check("stall_ready", int'(ready_a & ready_b), 1);
            end
            diff_valid = 1'b1;
            diff = 5'(d[i]);
            check("ready", int'(ready_a & ready_b), 1);
            @(negedge clk);
        end
        diff_valid = 1'b0;
        check("done_valid8", int'(valid_a), 1);
        check("done_valid6", int'(valid_b), 1);
        check("done_acc8",   int'(acc_a), exp_q.pop_front());
        check("done_acc6",   int'(acc_b), e6);
        check("done_sat8",   int'(sat_a), s8);
        check("done_sat6",   int'(sat_b), s6);
        check("done_ready",  int'(ready_a), 0);
        start = poke; diff_valid = poke; diff = 5'd7;
        @(negedge clk);
        start = 1'b0; diff_valid = 1'b0;
        check("post_valid", int'(valid_a | valid_b), 0);
        check("post_busy",  int'(busy_a | busy_b), 0);
        check("hold_acc8",  int'(acc_a), e8);
        check("hold_acc6",  int'(acc_b), e6);
    endtask

    // diff_valid pulses while idle must not disturb the held result.
    task automatic idle_noise();
        int h8, h6;
        h8 = int'(acc_a); h6 = int'(acc_b);
        repeat (3) begin
            diff_valid = 1'b1;
            diff = 5'($urandom);
            @(negedge clk);
            check("idle_ready", int'(ready_a | ready_b), 0);
        end
        diff_valid = 1'b0;
        check("idle_acc8", int'(acc_a), h8);
        check("idle_acc6", int'(acc_b), h6);
        check("idle_busy2", int'(busy_a), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rd[4];
        do_reset();

        run_frame('{1, -5, 9, -2}, 0, 0, 1'b0);
        run_frame('{1, -5, 9, -2}, 2, 2, 1'b0);
        run_frame('{15, 15, 15, 15}, 0, 0, 1'b0);
        run_frame('{-16, -16, -16, -16}, 0, 0, 1'b0);
        run_frame('{1, -5, 9, -2}, 1, 2, 1'b1);
        idle_noise();

        // Reset in the middle of a frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        diff_valid = 1'b1;
        diff = 5'd9;
        repeat (2) @(negedge clk);
        diff_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc8",  int'(acc_a), 0);
        check("mid_rst_acc6",  int'(acc_b), 0);
        check("mid_rst_valid", int'(valid_a | valid_b), 0);
        check("mid_rst_busy",  int'(busy_a | busy_b), 0);
        check("mid_rst_ready", int'(ready_a | ready_b), 0);
        check("mid_rst_sat",   int'(sat_a | sat_b), 0);
        @(negedge clk);
        check("mid_rst_novalid", int'(valid_a | valid_b), 0);
        rst_n = 1'b1;
        run_frame('{3, 3, 3, 3}, 0, 0, 1'b0);

        // Random frames.
        for (int f = 0; f < 24; f++) begin
            foreach (rd[i]) rd[i] = int'($urandom_range(0, 31)) - 16;
            run_frame(rd, 0, 3, 1'($urandom_range(0, 1)));
            if (f % 6 == 5) idle_noise();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/signed_diff_accumulator.md
SIGNED_DIFF_ACCUMULATOR -- requirements
Module: signed_diff_accumulator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_SAMPLES, default 4: number of differences accumulated per frame, legal range 1..255.
REQ-003 Parameter ACC_W, default 8: accumulator width in bits, legal range 6..16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse that begins a frame.
REQ-007 diff  input  5  signed two's-complement difference from the upstream signed subtractor, range -16..15.
REQ-008 diff_valid  input  1  diff is valid this cycle.
REQ-009 diff_ready  output  1  block accepts diff this cycle.
REQ-010 acc_out  output  ACC_W  signed frame sum.
REQ-011 acc_valid  output  1  one-cycle pulse indicating that acc_out holds a completed frame sum.
REQ-012 sat_flag  output  1  saturation occurred in the frame held in acc_out.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-015 IDLE -> ACCUM on start=1; on that edge the accumulator SHALL be set to 0, the sample counter to 0 and sat_flag to 0.
REQ-016 A diff SHALL be accepted only on a clock edge where diff_valid=1 and diff_ready=1.
REQ-017 diff_ready SHALL be 1 only in ACCUM and SHALL be driven combinationally from the state.
REQ-018 On each accepted diff, the block SHALL sign-extend diff to ACC_W+1 bits, add it to the accumulator, and increment the counter.
REQ-019 ACCUM -> DONE on the edge that accepts the N_SAMPLES-th diff; that diff SHALL be included in the sum.
REQ-020 In DONE, acc_out SHALL present the final sum, acc_valid SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-021 Latency: acc_valid SHALL assert in the cycle immediately after the last diff is accepted.
REQ-022 acc_out SHALL be registered and SHALL hold its value in IDLE until the next start clears it.
REQ-023 acc_out is undefined-for-use mid-frame; only the value at acc_valid=1 is meaningful.
REQ-024 start SHALL be ignored in ACCUM and in DONE.
REQ-025 diff_valid SHALL be ignored in IDLE and in DONE; no diff is consumed in those states.
REQ-026 Gaps in diff_valid during ACCUM SHALL stall the frame without changing the accumulator or counter.
REQ-027 busy SHALL be 1 in ACCUM and in DONE, and 0 in IDLE.

Reset
REQ-028 On rst_n=0, regardless of state or clock, the block SHALL immediately force: state=IDLE, acc_out=0, counter=0, acc_valid=0, sat_flag=0, busy=0, diff_ready=0.
REQ-029 A reset asserted mid-frame SHALL discard the partial sum, and no acc_valid pulse SHALL be produced for that frame.
REQ-030 After rst_n deasserts, the block SHALL accept start on the first rising clock edge.

Configuration
REQ-031 The block SHALL honour the macro SIGNED_DIFF_ACC_SAT_EN.
REQ-032 With SIGNED_DIFF_ACC_SAT_EN defined, the block SHALL saturate each addition result to the range -2^(ACC_W-1) .. 2^(ACC_W-1)-1.
REQ-033 With SIGNED_DIFF_ACC_SAT_EN defined, sat_flag SHALL be set sticky for the frame whenever a clamp occurs.
REQ-034 With SIGNED_DIFF_ACC_SAT_EN undefined, additions SHALL wrap modulo 2^ACC_W.
REQ-035 With SIGNED_DIFF_ACC_SAT_EN undefined, sat_flag SHALL be tied to 0.

Verification
REQ-036 The bench SHALL cover each of the following directed scenarios:
- Defaults: start, then diffs 1, -5, 9, -2 back-to-back -> acc_out=3 and acc_valid pulses one cycle after the 4th acceptance; sat_flag=0.
- Backpressure: same diffs with diff_valid low for 2 cycles between each -> same result (acc_out=3); diff_ready=1 throughout ACCUM.
- ACC_W=6, macro defined: four diffs of 15 -> acc_out=31, sat_flag=1; four diffs of -16 -> acc_out=-32, sat_flag=1.
- ACC_W=6, macro undefined: four diffs of 15 -> acc_out=-4 (60 wrapped modulo 64), sat_flag=0.
- Reset mid-frame: start, accept 2 diffs, pulse rst_n low -> all outputs 0 immediately; no acc_valid; new frame 3, 3, 3, 3 -> acc_out=12.
- start asserted during ACCUM, and diff_valid=1 in IDLE -> both ignored; the frame sum is unchanged.
